// File: rtl/sdf_stage4_butterfly_if.sv
// Stream/ROM bundle of the stage-4 SDF butterfly: input stream, twiddle ROM port and output stream.
// The master side is the environment (upstream source, twiddle ROM, downstream sink).
interface sdf_stage4_butterfly_if #(
    parameter int DW = 22
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] din_real;
    logic [DW-1:0] din_imag;
    logic [5:0]    rom_addr;
    logic [DW-1:0] tw_real;
    logic [DW-1:0] tw_imag;
    logic          out_valid;
    logic [DW-1:0] dout_real;
    logic [DW-1:0] dout_imag;

    modport master (
        output in_valid, din_real, din_imag, tw_real, tw_imag,
        input  in_ready, rom_addr, out_valid, dout_real, dout_imag
    );

    modport slave (
        input  in_valid, din_real, din_imag, tw_real, tw_imag,
        output in_ready, rom_addr, out_valid, dout_real, dout_imag
    );
endinterface

// File: rtl/sdf_stage4_butterfly.sv
// Stage-4 radix-2 DIF butterfly of a 32-point SDF FFT with a 4-deep feedback delay.
// Sums leave with W=1, differences are recirculated and later rotated by the stage-4 twiddle.
module sdf_stage4_butterfly #(
    parameter int DW   = 22,
    parameter int FRAC = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdf_stage4_butterfly_if.slave bus
);
    localparam int DEPTH = 4;
    localparam logic signed [2*DW:0] LP_HALF =
        {{(2*DW-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0] r_cnt;
    logic [1:0] r_dcnt;
    logic       r_pending;

    logic signed [DW-1:0] r_dl_re [DEPTH];
    logic signed [DW-1:0] r_dl_im [DEPTH];
    logic signed [DW-1:0] w_dl_re_next [DEPTH];
    logic signed [DW-1:0] w_dl_im_next [DEPTH];

    logic          r_out_valid;
    logic [DW-1:0] r_dout_re;
    logic [DW-1:0] r_dout_im;

    logic       w_in_ready;
    logic       w_accept;
    logic       w_shift;
    logic       w_emit;
    logic       w_is_diff;
    logic [1:0] w_k;

    logic signed [DW-1:0] w_din_re, w_din_im;
    logic signed [DW-1:0] w_tw_re, w_tw_im;
    logic signed [DW-1:0] w_head_re, w_head_im;
    logic signed [DW-1:0] w_sum_re, w_sum_im;
    logic signed [DW-1:0] w_dif_re, w_dif_im;
    logic signed [DW-1:0] w_push_re, w_push_im;
    logic signed [DW-1:0] w_cand_re, w_cand_im;
    logic signed [2*DW:0] w_prod_re, w_prod_im;
    logic signed [2*DW:0] w_rnd_re, w_rnd_im;
    logic [DW-1:0]        w_out_re, w_out_im;
    logic                 w_unused_bits;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // Drain only starts on a block boundary with differences still parked in the delay line.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (!bus.in_valid && (r_cnt == 3'd0) && r_pending) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_dcnt == 2'd3) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_shift    = 1'b0;
        w_emit     = 1'b0;
        w_is_diff  = 1'b0;
        w_k        = 2'd0;
        case (r_state)
            ST_RUN: begin
                w_in_ready = 1'b1;
                w_accept   = bus.in_valid;
                w_shift    = bus.in_valid;
                w_is_diff  = !r_cnt[2] && r_pending;
                w_emit     = bus.in_valid && (r_cnt[2] || r_pending);
                w_k        = r_cnt[1:0];
            end
            ST_DRAIN: begin
                w_shift   = 1'b1;
                w_emit    = 1'b1;
                w_is_diff = 1'b1;
                w_k       = r_dcnt;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    // ---------------- counters and pending flag ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 3'd0;
            r_dcnt    <= 2'd0;
            r_pending <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_pending <= 1'b1;
                end else if (r_cnt == 3'd3) begin
                    r_pending <= 1'b0;
                end
            end
            if (r_state == ST_DRAIN) begin
                r_dcnt <= r_dcnt + 2'd1;
                if (r_dcnt == 2'd3) begin
                    r_pending <= 1'b0;
                end
            end
        end
    end

    // ---------------- butterfly ----------------
    assign w_din_re  = bus.din_real;
    assign w_din_im  = bus.din_imag;
    assign w_tw_re   = bus.tw_real;
    assign w_tw_im   = bus.tw_imag;
    assign w_head_re = r_dl_re[0];
    assign w_head_im = r_dl_im[0];

    assign w_sum_re = w_head_re + w_din_re;
    assign w_sum_im = w_head_im + w_din_im;
    assign w_dif_re = w_head_re - w_din_re;
    assign w_dif_im = w_head_im - w_din_im;

    always_comb begin
        w_push_re = w_din_re;
        w_push_im = w_din_im;
        w_cand_re = w_head_re;
        w_cand_im = w_head_im;
        if (r_state == ST_DRAIN) begin
            w_push_re = '0;
            w_push_im = '0;
        end else if (r_cnt[2]) begin
            w_push_re = w_dif_re;
            w_push_im = w_dif_im;
            w_cand_re = w_sum_re;
            w_cand_im = w_sum_im;
        end
    end

    // ---------------- feedback delay line (index 0 is the oldest entry) ----------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dl
        if (gi == DEPTH - 1) begin : g_tail
            assign w_dl_re_next[gi] = w_push_re;
            assign w_dl_im_next[gi] = w_push_im;
        end else begin : g_body
            assign w_dl_re_next[gi] = r_dl_re[gi+1];
            assign w_dl_im_next[gi] = r_dl_im[gi+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_re <= '{default: '0};
            r_dl_im <= '{default: '0};
        end else if (w_shift) begin
            r_dl_re <= w_dl_re_next;
            r_dl_im <= w_dl_im_next;
        end
    end

    // ---------------- twiddle rotation, round half up, keep low DW bits ----------------
    assign w_prod_re = w_cand_re * w_tw_re - w_cand_im * w_tw_im;
    assign w_prod_im = w_cand_re * w_tw_im + w_cand_im * w_tw_re;
    assign w_rnd_re  = w_prod_re + LP_HALF;
    assign w_rnd_im  = w_prod_im + LP_HALF;
    assign w_out_re  = w_rnd_re[FRAC +: DW];
    assign w_out_im  = w_rnd_im[FRAC +: DW];

    assign w_unused_bits = ^{w_rnd_re[FRAC-1:0], w_rnd_re[2*DW:FRAC+DW],
                             w_rnd_im[FRAC-1:0], w_rnd_im[2*DW:FRAC+DW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_dout_re   <= '0;
            r_dout_im   <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_dout_re <= w_out_re;
                r_dout_im <= w_out_im;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.rom_addr  = w_is_diff ? {4'b0010, w_k} : 6'd0;
    assign bus.out_valid = r_out_valid;
    assign bus.dout_real = r_dout_re;
    assign bus.dout_imag = r_dout_im;
endmodule

// File: tb/tb_sdf_stage4_butterfly.sv
// Directed bench for the stage-4 SDF butterfly: scoreboard of expected outputs with twiddle ROM model.
module tb_sdf_stage4_butterfly;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sdf_stage4_butterfly_if #(.DW(22)) bus ();

    sdf_stage4_butterfly #(.DW(22), .FRAC(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // stage-4 twiddle ROM: addresses 8..11 hold W32^(4k) = e^(-j*2*pi*k/8), Q6
    always_comb begin
        case (bus.rom_addr)
            6'd9:    begin bus.tw_real = 22'sd45;  bus.tw_imag = -22'sd45; end
            6'd10:   begin bus.tw_real = 22'sd0;   bus.tw_imag = -22'sd64; end
            6'd11:   begin bus.tw_real = -22'sd45; bus.tw_imag = -22'sd45; end
            default: begin bus.tw_real = 22'sd64;  bus.tw_imag = 22'sd0;   end
        endcase
    end

    typedef struct {
        logic [21:0] re;
        logic [21:0] im;
        logic [5:0]  addr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;
    logic [5:0] last_addr = 6'd0;
    logic signed [21:0] blk_re [8];
    logic signed [21:0] blk_im [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [21:0] re, input logic [21:0] im, input logic [5:0] addr);
        exp_t e;
        e.re = re;
        e.im = im;
        e.addr = addr;
        sb.push_back(e);
    endtask

    function automatic logic [21:0] rnd6(input logic signed [44:0] p);
        logic signed [44:0] q;
        q = (p + 45'sd32) >>> 6;
        return q[21:0];
    endfunction

    // Reference: X[n]+X[n+4] with W=1, then (X[n]-X[n+4])*e^(-j*2*pi*n/8)
    task automatic expect_block();
        logic signed [21:0] dr, di, wr, wi;
        logic signed [44:0] pr, pi;
        for (int n = 0; n < 4; n++) begin
            dr = blk_re[n] + blk_re[n+4];
            di = blk_im[n] + blk_im[n+4];
            push_exp(dr, di, 6'd0);
        end
        for (int n = 0; n < 4; n++) begin
            dr = blk_re[n] - blk_re[n+4];
            di = blk_im[n] - blk_im[n+4];
            case (n)
                1:       begin wr = 22'sd45;  wi = -22'sd45; end
                2:       begin wr = 22'sd0;   wi = -22'sd64; end
                3:       begin wr = -22'sd45; wi = -22'sd45; end
                default: begin wr = 22'sd64;  wi = 22'sd0;   end
            endcase
            pr = dr * wr - di * wi;
            pi = dr * wi + di * wr;
            push_exp(rnd6(pr), rnd6(pi), 6'(8 + n));
        end
    endtask

    task automatic expect_t1();
        push_exp(22'd6, 22'd0, 6'd0);
        push_exp(22'd8, 22'd0, 6'd0);
        push_exp(22'd10, 22'd0, 6'd0);
        push_exp(22'd12, 22'd0, 6'd0);
        push_exp(22'(-4), 22'd0, 6'd8);
        push_exp(22'(-3), 22'd3, 6'd9);
        push_exp(22'd0, 22'd4, 6'd10);
        push_exp(22'd3, 22'd3, 6'd11);
    endtask

    task automatic put(input logic [21:0] re, input logic [21:0] im, input bit exp_ov);
        check("in_ready_before_put", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.din_real = re;
        bus.din_imag = im;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("out_valid_after_put", {63'd0, bus.out_valid}, {63'd0, exp_ov});
    endtask

    task automatic idle(input int n, input bit chk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (chk) check("out_valid_idle", {63'd0, bus.out_valid}, 64'd0);
        end
    endtask

    task automatic send_block(input int gap_after, input int gap_len, input bit pend);
        for (int i = 0; i < 8; i++) begin
            put(blk_re[i], blk_im[i], (i >= 4) || pend);
            if (i == gap_after) idle(gap_len, 1'b1);
        end
    endtask

    task automatic wait_empty(input int limit);
        int c = 0;
        while (sb.size() != 0 && c < limit) begin
            @(posedge clk);
            #1;
            c++;
        end
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL drain_timeout observed=%0d left expected=0 left", sb.size());
        end
    endtask

    // scoreboard monitor: rom_addr is compared as seen in the producing cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            n_out++;
            $display("out re=%0h im=%0h addr=%0d", bus.dout_real, bus.dout_imag, last_addr);
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_output observed=%0h expected=none", bus.dout_real);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("dout_real", {42'd0, bus.dout_real}, {42'd0, e.re});
                check("dout_imag", {42'd0, bus.dout_imag}, {42'd0, e.im});
                check("rom_addr", {58'd0, last_addr}, {58'd0, e.addr});
            end
        end
        last_addr = bus.rom_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.din_real = '0;
        bus.din_imag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_dout_real", {42'd0, bus.dout_real}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_rom_addr", {58'd0, bus.rom_addr}, 64'd0);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // T1: single block re=1..8, then drain
        for (int i = 0; i < 8; i++) begin
            blk_re[i] = 22'(i + 1);
            blk_im[i] = 22'd0;
        end
        expect_t1();
        send_block(-1, 0, 1'b0);
        @(posedge clk);
        #1;
        check("t1_gap_before_drain", {63'd0, bus.out_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("t1_drain_in_ready", {63'd0, bus.in_ready}, 64'd0);
            check("t1_drain_rom_addr", {58'd0, bus.rom_addr}, 64'(8 + i));
            @(posedge clk);
            #1;
            check("t1_drain_out_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        check("t1_in_ready_after", {63'd0, bus.in_ready}, 64'd1);
        wait_empty(10);
        idle(2, 1'b1);

        // T3: T1 with a 3-cycle bubble after the 3rd sample
        expect_t1();
        send_block(2, 3, 1'b0);
        wait_empty(20);
        idle(2, 1'b1);

        // T2/T6: two back-to-back random blocks
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            blk_re[i] = 22'($urandom);
            blk_im[i] = 22'($urandom);
        end
        expect_block();
        send_block(-1, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            blk_re[i] = 22'($urandom);
            blk_im[i] = 22'($urandom);
        end
        expect_block();
        send_block(-1, 0, 1'b1);
        wait_empty(20);
        idle(2, 1'b1);
        check("t2_output_count", 64'(n_out - base), 64'd16);

        // T4: wrap-around in the butterfly
        for (int i = 0; i < 8; i++) begin
            blk_re[i] = 22'd0;
            blk_im[i] = 22'd0;
        end
        blk_re[0] = 22'h1FFFFF;
        blk_re[4] = 22'd1;
        push_exp(22'h200000, 22'd0, 6'd0);
        push_exp(22'd0, 22'd0, 6'd0);
        push_exp(22'd0, 22'd0, 6'd0);
        push_exp(22'd0, 22'd0, 6'd0);
        push_exp(22'h1FFFFE, 22'd0, 6'd8);
        push_exp(22'd0, 22'd0, 6'd9);
        push_exp(22'd0, 22'd0, 6'd10);
        push_exp(22'd0, 22'd0, 6'd11);
        send_block(-1, 0, 1'b0);
        wait_empty(20);
        idle(2, 1'b1);

        // T5: reset during the 2nd drain cycle
        for (int i = 0; i < 8; i++) begin
            blk_re[i] = 22'($urandom_range(0, 1000));
            blk_im[i] = 22'($urandom_range(0, 1000));
        end
        expect_block();
        send_block(-1, 0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t5_in_drain", {63'd0, bus.in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("t5_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("t5_rst_rom_addr", {58'd0, bus.rom_addr}, 64'd0);
        check("t5_rst_dout_imag", {42'd0, bus.dout_imag}, 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3, 1'b1);
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            blk_re[i] = 22'($urandom);
            blk_im[i] = 22'($urandom);
        end
        expect_block();
        send_block(-1, 0, 1'b0);
        wait_empty(20);
        idle(3, 1'b1);
        check("t5_output_count", 64'(n_out - base), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
